layer_sched: RTL and testbench

Sequencer that time-multiplexes one shared `neu` neuron (two-stage FP32 weighted sum plus activation) across all neurons of a layer. On `start` it latches the three FP32 layer inputs, then per neuron index fetches the three FP32 weights from weight memory, drives them onto the neuron, waits out the neuron latency, writes the result to the layer output buffer and strobes the neuron's backprop capture lines. It sits between the layer-level control and the `neu` datapath and is the only driver of the neuron's operand and read-strobe inputs.

---
 rtl/layer_sched.sv | 127 ++++++++++++
 tb/tb_layer_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/layer_sched.sv
// layer_sched: time-multiplexes one shared neu neuron across all neurons of a layer.
// Optional macro LAYER_SCHED_BACKPROP_EN drives z_read/h_read during each WRITE cycle.
module layer_sched #(
    parameter int NEURONS = 4,
    parameter int NEU_LAT = 6,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   x1,
    input  logic [31:0]   x2,
    input  logic [31:0]   x3,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] w_addr,
    input  logic [95:0]   w_rdata,
    output logic [31:0]   neu_x1,
    output logic [31:0]   neu_x2,
    output logic [31:0]   neu_x3,
    output logic [31:0]   neu_w1,
    output logic [31:0]   neu_w2,
    output logic [31:0]   neu_w3,
    input  logic [31:0]   neu_out,
    output logic          z_read,
    output logic          h_read,
    output logic          y_we,
    output logic [AW-1:0] y_addr,
    output logic [31:0]   y_data
);

    localparam int CW = (NEU_LAT > 1) ? $clog2(NEU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(NEU_LAT - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [95:0]   x_q, x_d;
    logic [95:0]   w_q, w_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = {x3, x2, x1};
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                // Memory data for idx arrives this cycle; weights then stay put until the next ISSUE.
                w_d     = w_rdata;
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                    (state_q == S_WAIT)  || (state_q == S_WRITE);
    assign done   = (state_q == S_DONE);
    assign w_addr = idx_q;
    assign y_addr = idx_q;
    assign y_we   = (state_q == S_WRITE);
    assign y_data = y_we ? neu_out : 32'h0;

    assign {neu_x3, neu_x2, neu_x1} = x_q;
    assign {neu_w3, neu_w2, neu_w1} = w_q;

`ifdef LAYER_SCHED_BACKPROP_EN
    assign z_read = (state_q == S_WRITE);
    assign h_read = (state_q == S_WRITE);
`else
    assign z_read = 1'b0;
    assign h_read = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: main 4x6 instance plus a 1x1 instance for back-to-back passes.
module tb_layer_sched;

`ifdef LAYER_SCHED_BACKPROP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mem_word(input logic [3:0] a);
        return {28'h3000000, a, 28'h2000000, a, 28'h1000000, a};
    endfunction

    // ---------------- DUT 1: NEURONS=4, NEU_LAT=6
    logic        start = 1'b0;
    logic [31:0] x1 = '0, x2 = '0, x3 = '0;
    logic        busy, done, y_we, z_read, h_read;
    logic [3:0]  w_addr, y_addr;
    logic [95:0] w_rdata = '0;
    logic [31:0] neu_x1, neu_x2, neu_x3, neu_w1, neu_w2, neu_w3, neu_out, y_data;

    always @(posedge clk) w_rdata <= mem_word(w_addr);
    assign neu_out = {28'h3F80000, neu_w1[3:0]};

    layer_sched #(.NEURONS(4), .NEU_LAT(6), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2), .x3(x3),
        .busy(busy), .done(done), .w_addr(w_addr), .w_rdata(w_rdata),
        .neu_x1(neu_x1), .neu_x2(neu_x2), .neu_x3(neu_x3),
        .neu_w1(neu_w1), .neu_w2(neu_w2), .neu_w3(neu_w3),
        .neu_out(neu_out), .z_read(z_read), .h_read(h_read),
        .y_we(y_we), .y_addr(y_addr), .y_data(y_data)
    );

    // ---------------- DUT 2: NEURONS=1, NEU_LAT=1
    logic        start2 = 1'b0;
    logic        busy2, done2, y_we2, z_read2, h_read2;
    logic [3:0]  w_addr2, y_addr2;
    logic [95:0] w_rdata2 = '0;
    logic [31:0] n2_x1, n2_x2, n2_x3, n2_w1, n2_w2, n2_w3, neu_out2, y_data2;

    always @(posedge clk) w_rdata2 <= mem_word(w_addr2);
    assign neu_out2 = {28'h3F80000, n2_w1[3:0]};

    layer_sched #(.NEURONS(1), .NEU_LAT(1), .AW(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .x1(x1), .x2(x2), .x3(x3),
        .busy(busy2), .done(done2), .w_addr(w_addr2), .w_rdata(w_rdata2),
        .neu_x1(n2_x1), .neu_x2(n2_x2), .neu_x3(n2_x3),
        .neu_w1(n2_w1), .neu_w2(n2_w2), .neu_w3(n2_w3),
        .neu_out(neu_out2), .z_read(z_read2), .h_read(h_read2),
        .y_we(y_we2), .y_addr(y_addr2), .y_data(y_data2)
    );

    initial begin
        int we_cnt;
        int k, ph;
        logic        e_we;
        logic [3:0]  e_idx;

        // Reset state
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_waddr", w_addr, 0);
        check_eq("rst_yaddr", y_addr, 0);
        check_eq("rst_ywe", y_we, 0);
        check_eq("rst_ydata", y_data, 0);
        check_eq("rst_nx", {neu_x3, neu_x2, neu_x1}, 0);
        check_eq("rst_nw", {neu_w3, neu_w2, neu_w1}, 0);
        check_eq("rst_zh", {z_read, h_read}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Pass A, aborted by reset in WAIT of neuron 2 (cycle 23)
        x1 = 32'h40A00000; x2 = 32'h40C00000; x3 = 32'h40E00000;
        start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            start = 1'b0;
        end
        check_eq("pre_abort_busy", busy, 1);
        check_eq("pre_abort_waddr", w_addr, 2);
        check_eq("pre_abort_nw", {neu_w3, neu_w2, neu_w1}, mem_word(4'd2));
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_waddr", w_addr, 0);
        check_eq("abort_nx", {neu_x3, neu_x2, neu_x1}, 0);
        check_eq("abort_nw", {neu_w3, neu_w2, neu_w1}, 0);
        check_eq("abort_ydata", y_data, 0);
        tick();
        tick();
        rst = 1'b0;
        we_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (y_we) we_cnt++;
        end
        check_eq("abort_no_ywe", we_cnt, 0);
        check_eq("abort_idle", busy, 0);

        // Pass B: full pass, start pulses in cycles 5 and 37 must be ignored
        x1 = 32'h3F800000; x2 = 32'h40000000; x3 = 32'h40400000;
        start = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            tick();
            start = 1'b0;
            k  = (c - 1) / 9;
            ph = (c - 1) % 9;
            e_we  = (c <= 36) && (ph == 8);
            e_idx = (c <= 36) ? 4'(k) : 4'd3;
            check_eq($sformatf("busy@%0d", c), busy, (c <= 36));
            check_eq($sformatf("done@%0d", c), done, (c == 37));
            check_eq($sformatf("ywe@%0d", c), y_we, e_we);
            check_eq($sformatf("yaddr@%0d", c), y_addr, e_idx);
            check_eq($sformatf("waddr@%0d", c), w_addr, e_idx);
            check_eq($sformatf("ydata@%0d", c), y_data, e_we ? {28'h3F80000, e_idx} : 32'h0);
            check_eq($sformatf("zh@%0d", c), {z_read, h_read}, (BP && e_we) ? 2'b11 : 2'b00);
            check_eq($sformatf("nx@%0d", c), {neu_x3, neu_x2, neu_x1},
                     {32'h40400000, 32'h40000000, 32'h3F800000});
            if (c <= 36 && ph >= 2)
                check_eq($sformatf("nw@%0d", c), {neu_w3, neu_w2, neu_w1}, mem_word(4'(k)));
            if (c == 5 || c == 37) start = 1'b1;
        end

        // DUT 2: start held high, expect a 6-cycle pass period
        start2 = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            ph = c % 6;
            check_eq($sformatf("b2_ywe@%0d", c), y_we2, (ph == 4));
            check_eq($sformatf("b2_done@%0d", c), done2, (ph == 5));
            check_eq($sformatf("b2_busy@%0d", c), busy2, (ph >= 1 && ph <= 4));
            check_eq($sformatf("b2_ydata@%0d", c), y_data2, (ph == 4) ? 32'h3F800000 : 32'h0);
            check_eq($sformatf("b2_zh@%0d", c), {z_read2, h_read2},
                     (BP && ph == 4) ? 2'b11 : 2'b00);
        end
        start2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
